// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers an A tile (M x K) and a B tile (K x M) from a
// ready/valid stream, one k-slice per beat, then replays them with a per-lane
// diagonal skew so PE(i,j) of an MxM systolic array accumulates A[i][k]*B[k][j].
// Optional feature macro: SYSTOLIC_FEEDER_CLR_EN. When defined, a one-cycle CLR
// state between loading and streaming pulses acc_clr; when undefined, streaming
// starts straight after the last beat and acc_clr is tied low.
module systolic_feeder #(
   parameter int N     = 32,
   parameter int M     = 6,
   parameter int K_MAX = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_last,
   input  logic signed [N-1:0] a_vec  [0:M-1],
   input  logic signed [N-1:0] b_vec  [0:M-1],
   output logic signed [N-1:0] x_feed [0:M-1],
   output logic signed [N-1:0] y_feed [0:M-1],
   output logic                array_en,
   output logic                acc_clr,
   output logic                busy,
   output logic                done,
   output logic                k_ovf
);

   localparam int CW = $clog2(K_MAX + 2*M);
   localparam int KW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] K_LAST  = CW'(K_MAX - 1);
   // Stream length is T = K + 2M - 1, so the final t is K + 2M - 2.
   localparam logic [CW-1:0] T_EXTRA = CW'(2*M - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
`ifdef SYSTOLIC_FEEDER_CLR_EN
      S_CLR,
`endif
      S_STREAM,
      S_DONE
   } state_t;

`ifdef SYSTOLIC_FEEDER_CLR_EN
   localparam state_t S_AFTER_LOAD = S_CLR;
`else
   localparam state_t S_AFTER_LOAD = S_STREAM;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] kcnt_q, kcnt_d;   // beats loaded; holds K while streaming
   logic [CW-1:0] t_q, t_d;         // stream cycle index
   logic          k_ovf_q, k_ovf_d;
   logic          beat_fire;
   logic          wr_en;

   // Operand buffers indexed by k: a_mem_q[k][i] = A[i][k], b_mem_q[k][j] = B[k][j].
   logic signed [N-1:0] a_mem_q [0:K_MAX-1][0:M-1];
   logic signed [N-1:0] b_mem_q [0:K_MAX-1][0:M-1];

   // Ready depends on state only; reset forces it low while asserted.
   assign in_ready  = !rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
   assign beat_fire = in_valid && in_ready;

   // Next-state, counter and sticky-overflow logic.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      state_d = state_q;
      kcnt_d  = kcnt_q;
      t_d     = t_q;
      k_ovf_d = k_ovf_q;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE, S_LOAD: begin
            if (beat_fire) begin
               wr_en  = 1'b1;
               kcnt_d = kcnt_q + ONE;
               // A new tile's first beat clears the previous overflow flag.
               if (state_q == S_IDLE) k_ovf_d = 1'b0;
               if (in_last || (kcnt_q == K_LAST)) begin
                  if (!in_last) k_ovf_d = 1'b1;
                  t_d     = '0;
                  state_d = S_AFTER_LOAD;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
`ifdef SYSTOLIC_FEEDER_CLR_EN
         S_CLR: begin
            state_d = S_STREAM;
         end
`endif
         S_STREAM: begin
            if (t_q == kcnt_q + T_EXTRA) state_d = S_DONE;
            else                         t_d     = t_q + ONE;
         end
         S_DONE: begin
            kcnt_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         kcnt_q  <= '0;
         t_q     <= '0;
         k_ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         kcnt_q  <= kcnt_d;
         t_q     <= t_d;
         k_ovf_q <= k_ovf_d;
      end
   end

   // Operand buffer write port: one k-slice per accepted beat.
   always_ff @(posedge clk) begin
      // NOTE: buffers carry no reset; entries beyond kcnt are never read, so stale data is harmless.
      if (wr_en) begin
         a_mem_q[kcnt_q[KW-1:0]] <= a_vec;
         b_mem_q[kcnt_q[KW-1:0]] <= b_vec;
      end
   end

   // Skewed read-out: lane i carries slice t-i while it lies inside 0..K-1.
   always_comb begin
      for (int i = 0; i < M; i++) begin
         x_feed[i] = '0;
         y_feed[i] = '0;
      end
      if (state_q == S_STREAM) begin
         for (int i = 0; i < M; i++) begin
            if ((t_q >= CW'(i)) && ((t_q - CW'(i)) < kcnt_q)) begin
               x_feed[i] = a_mem_q[KW'(t_q - CW'(i))][i];
               y_feed[i] = b_mem_q[KW'(t_q - CW'(i))][i];
            end
         end
      end
   end

   assign array_en = (state_q == S_STREAM);
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign k_ovf    = k_ovf_q;
`ifdef SYSTOLIC_FEEDER_CLR_EN
   assign acc_clr  = (state_q == S_CLR);
`else
   assign acc_clr  = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder (M=2, N=16, K_MAX=4). Expected feeds come from
// the skew rule applied to the stored tile; a behavioural PE-array model run on
// the observed feeds must reproduce the plain matrix product.
module tb_systolic_feeder;

   localparam int N     = 16;
   localparam int M     = 2;
   localparam int K_MAX = 4;
   localparam int TRACE = 32;
`ifdef SYSTOLIC_FEEDER_CLR_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic                in_last = 1'b0;
   logic signed [N-1:0] a_vec  [0:M-1];
   logic signed [N-1:0] b_vec  [0:M-1];
   logic signed [N-1:0] x_feed [0:M-1];
   logic signed [N-1:0] y_feed [0:M-1];
   logic                array_en, acc_clr, busy, done, k_ovf;

   systolic_feeder #(.N(N), .M(M), .K_MAX(K_MAX)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_last  (in_last),
      .a_vec    (a_vec),
      .b_vec    (b_vec),
      .x_feed   (x_feed),
      .y_feed   (y_feed),
      .array_en (array_en),
      .acc_clr  (acc_clr),
      .busy     (busy),
      .done     (done),
      .k_ovf    (k_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Tile under test: ta[i][k] = A[i][k], tbm[k][j] = B[k][j].
   logic signed [N-1:0] ta  [0:M-1][0:K_MAX-1];
   logic signed [N-1:0] tbm [0:K_MAX-1][0:M-1];

   // Observed trace, index n = cycles after the cycle the last beat was driven.
   logic signed [N-1:0] ox [0:TRACE-1][0:M-1];
   logic signed [N-1:0] oy [0:TRACE-1][0:M-1];
   logic o_ready [0:TRACE-1];
   logic o_busy  [0:TRACE-1];
   logic o_en    [0:TRACE-1];
   logic o_clr   [0:TRACE-1];
   logic o_done  [0:TRACE-1];
   logic o_kovf  [0:TRACE-1];
   int   load_rdy_bad;

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = 0; i < M; i++) begin
         a_vec[i] = '0;
         b_vec[i] = '0;
      end
   endtask

   task automatic rand_inputs();
      in_last = 1'($urandom_range(0, 1));
      for (int i = 0; i < M; i++) begin
         a_vec[i] = N'($urandom);
         b_vec[i] = N'($urandom);
      end
   endtask

   task automatic rand_tile();
      for (int k = 0; k < K_MAX; k++)
         for (int i = 0; i < M; i++) begin
            ta[i][k]  = N'($urandom);
            tbm[k][i] = N'($urandom);
         end
   endtask

   // Drive k beats of the stored tile; optional idle gaps between beats.
   task automatic load_beats(input int k, input bit use_last, input bit noisy);
      load_rdy_bad = 0;
      for (int b = 0; b < k; b++) begin
         if (noisy && ($urandom_range(0, 2) == 0)) begin
            @(negedge clk);
            rand_inputs();
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_ready !== 1'b1) load_rdy_bad++;
         in_valid = 1'b1;
         in_last  = use_last && (b == k - 1);
         for (int i = 0; i < M; i++) begin
            a_vec[i] = ta[i][b];
            b_vec[i] = tbm[b][i];
         end
      end
   endtask

   // Record len cycles of outputs; noisy keeps in_valid high with random data.
   task automatic capture(input int len, input bit noisy);
      for (int n = 1; n <= len; n++) begin
         @(negedge clk);
         o_ready[n] = in_ready;
         o_busy[n]  = busy;
         o_en[n]    = array_en;
         o_clr[n]   = acc_clr;
         o_done[n]  = done;
         o_kovf[n]  = k_ovf;
         for (int i = 0; i < M; i++) begin
            ox[n][i] = x_feed[i];
            oy[n][i] = y_feed[i];
         end
         if (noisy && (n < len)) begin
            rand_inputs();
            in_valid = 1'b1;
         end else begin
            idle_inputs();
         end
      end
   endtask

   function automatic int tile_len(input int k);
      return GAP + (k + 2*M - 1) + 2;
   endfunction

   task automatic run_tile(input int k, input bit use_last, input bit noisy);
      load_beats(k, use_last, noisy);
      capture(tile_len(k), noisy);
   endtask

   // Skew rule: lane i at stream cycle t carries slice t-i when 0 <= t-i < K.
   function automatic logic signed [N-1:0] exp_x(input int k, input int n, input int i);
      int t;
      t = n - 1 - GAP;
      if (t < 0 || t >= k + 2*M - 1 || t - i < 0 || t - i >= k) return '0;
      return ta[i][t-i];
   endfunction

   function automatic logic signed [N-1:0] exp_y(input int k, input int n, input int j);
      int t;
      t = n - 1 - GAP;
      if (t < 0 || t >= k + 2*M - 1 || t - j < 0 || t - j >= k) return '0;
      return tbm[t-j][j];
   endfunction

   // PE(i,j) sees row feed i delayed j cycles and column feed j delayed i cycles.
   function automatic longint pe_acc(input int len, input int i, input int j);
      longint s;
      s = 0;
      for (int n = 1; n <= len; n++)
         if (n - j >= 1 && n - i >= 1 && o_en[n])
            s += longint'(ox[n-j][i]) * longint'(oy[n-i][j]);
      return s;
   endfunction

   function automatic longint mat_ref(input int k, input int i, input int j);
      longint s;
      s = 0;
      for (int kk = 0; kk < k; kk++) s += longint'(ta[i][kk]) * longint'(tbm[kk][j]);
      return s;
   endfunction

   task automatic test_reset();
      logic [5:0] ctl;
      rst = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      ctl = {in_ready, busy, array_en, acc_clr, done, k_ovf};
      checks++;
      if (ctl !== 6'b0) begin
         errors++;
         $display("FAIL reset_hold ctl(rdy,busy,en,clr,done,ovf) got %b want 000000", ctl);
      end
      rst = 1'b0;
      @(negedge clk);
      ctl = {in_ready, busy, array_en, acc_clr, done, k_ovf};
      checks++;
      if (ctl !== 6'b100000) begin
         errors++;
         $display("FAIL reset_release ctl got %b want 100000", ctl);
      end
      for (int i = 0; i < M; i++) begin
         checks++;
         if (x_feed[i] !== '0 || y_feed[i] !== '0) begin
            errors++;
            $display("FAIL reset_feeds lane %0d got x=%0d y=%0d want 0", i, x_feed[i], y_feed[i]);
         end
      end
   endtask

   task automatic test_basic();
      int ex [0:1][0:4] = '{'{1, 2, 0, 0, 0}, '{0, 3, 4, 0, 0}};
      int ey [0:1][0:4] = '{'{5, 7, 0, 0, 0}, '{0, 6, 8, 0, 0}};
      longint acc_exp [0:1][0:1] = '{'{19, 22}, '{43, 50}};
      logic signed [N-1:0] e;
      int first_done, n_done, len;
      ta[0][0] = 1;  ta[1][0] = 3;  tbm[0][0] = 5;  tbm[0][1] = 6;
      ta[0][1] = 2;  ta[1][1] = 4;  tbm[1][0] = 7;  tbm[1][1] = 8;
      len = tile_len(2);
      run_tile(2, 1'b1, 1'b0);
      for (int t = 0; t < 5; t++)
         for (int i = 0; i < M; i++) begin
            checks++;
            e = N'(ex[i][t]);
            if (ox[GAP+1+t][i] !== e) begin
               errors++;
               $display("FAIL basic_x t=%0d lane %0d got %0d want %0d", t, i, ox[GAP+1+t][i], e);
            end
            checks++;
            e = N'(ey[i][t]);
            if (oy[GAP+1+t][i] !== e) begin
               errors++;
               $display("FAIL basic_y t=%0d lane %0d got %0d want %0d", t, i, oy[GAP+1+t][i], e);
            end
         end
      first_done = -1;
      n_done = 0;
      for (int n = 1; n <= len; n++)
         if (o_done[n] === 1'b1) begin
            if (first_done < 0) first_done = n;
            n_done++;
         end
      checks++;
      if (first_done != GAP + 5 + 1 || n_done != 1) begin
         errors++;
         $display("FAIL basic_done at c+%0d (count %0d) want c+%0d (count 1)", first_done, n_done, GAP + 6);
      end
      checks++;
      if ({o_clr[1], o_en[1]} !== {1'(GAP), 1'(1 - GAP)}) begin
         errors++;
         $display("FAIL basic_clr_gap clr,en at c+1 got %b%b want %0d%0d", o_clr[1], o_en[1], GAP, 1 - GAP);
      end
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) begin
            checks++;
            if (pe_acc(len, i, j) != acc_exp[i][j]) begin
               errors++;
               $display("FAIL basic_acc PE(%0d,%0d) got %0d want %0d", i, j, pe_acc(len, i, j), acc_exp[i][j]);
            end
         end
   endtask

   task automatic test_single_beat();
      int ex [0:1][0:3] = '{'{-3, 0, 0, 0}, '{0, 7, 0, 0}};
      int ey [0:1][0:3] = '{'{2, 0, 0, 0}, '{0, -1, 0, 0}};
      logic signed [N-1:0] e;
      ta[0][0] = -16'sd3;  ta[1][0] = 16'sd7;
      tbm[0][0] = 16'sd2;  tbm[0][1] = -16'sd1;
      run_tile(1, 1'b1, 1'b0);
      for (int t = 0; t < 4; t++)
         for (int i = 0; i < M; i++) begin
            checks++;
            e = N'(ex[i][t]);
            if (ox[GAP+1+t][i] !== e || o_en[GAP+1+t] !== 1'b1) begin
               errors++;
               $display("FAIL single_x t=%0d lane %0d got %0d en=%b want %0d en=1", t, i, ox[GAP+1+t][i], o_en[GAP+1+t], e);
            end
            checks++;
            e = N'(ey[i][t]);
            if (oy[GAP+1+t][i] !== e) begin
               errors++;
               $display("FAIL single_y t=%0d lane %0d got %0d want %0d", t, i, oy[GAP+1+t][i], e);
            end
         end
      checks++;
      if (o_done[GAP+5] !== 1'b1 || o_en[GAP+5] !== 1'b0) begin
         errors++;
         $display("FAIL single_done done,en at c+%0d got %b%b want 10", GAP + 5, o_done[GAP+5], o_en[GAP+5]);
      end
   endtask

   // Random tiles compared cycle by cycle; noisy keeps in_valid asserted during CLR/STREAM.
   task automatic test_random_tiles(input int n_tiles, input bit noisy, input string tag);
      int k, len, t_len;
      bit use_last;
      logic [4:0] ctl, ctl_exp;
      logic signed [N-1:0] e;
      for (int r = 0; r < n_tiles; r++) begin
         k = $urandom_range(1, K_MAX);
         use_last = (k < K_MAX) ? 1'b1 : 1'($urandom_range(0, 1));
         rand_tile();
         len = tile_len(k);
         t_len = k + 2*M - 1;
         run_tile(k, use_last, noisy);
         checks++;
         if (load_rdy_bad != 0) begin
            errors++;
            $display("FAIL %s_load_ready tile %0d low on %0d beats want 0", tag, r, load_rdy_bad);
         end
         checks++;
         if (o_kovf[1] !== 1'(k == K_MAX && !use_last)) begin
            errors++;
            $display("FAIL %s_kovf tile %0d got %b want %0d", tag, r, o_kovf[1], (k == K_MAX && !use_last));
         end
         for (int n = 1; n <= len; n++) begin
            ctl = {o_ready[n], o_busy[n], o_en[n], o_clr[n], o_done[n]};
            ctl_exp = {1'(n == len), 1'(n < len), 1'(n > GAP && n <= GAP + t_len),
                       1'(GAP == 1 && n == 1), 1'(n == GAP + t_len + 1)};
            checks++;
            if (ctl !== ctl_exp) begin
               errors++;
               $display("FAIL %s_ctl tile %0d k=%0d c+%0d (rdy,busy,en,clr,done) got %b want %b", tag, r, k, n, ctl, ctl_exp);
            end
            for (int i = 0; i < M; i++) begin
               checks++;
               e = exp_x(k, n, i);
               if (ox[n][i] !== e) begin
                  errors++;
                  $display("FAIL %s_x tile %0d c+%0d lane %0d got %0d want %0d", tag, r, n, i, ox[n][i], e);
               end
               checks++;
               e = exp_y(k, n, i);
               if (oy[n][i] !== e) begin
                  errors++;
                  $display("FAIL %s_y tile %0d c+%0d lane %0d got %0d want %0d", tag, r, n, i, oy[n][i], e);
               end
            end
         end
         for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
               checks++;
               if (pe_acc(len, i, j) != mat_ref(k, i, j)) begin
                  errors++;
                  $display("FAIL %s_acc tile %0d PE(%0d,%0d) got %0d want %0d", tag, r, i, j, pe_acc(len, i, j), mat_ref(k, i, j));
               end
            end
      end
   endtask

   task automatic test_overflow();
      int len;
      rand_tile();
      len = tile_len(K_MAX);
      run_tile(K_MAX, 1'b0, 1'b0);
      checks++;
      if (o_kovf[1] !== 1'b1 || o_ready[1] !== 1'b0) begin
         errors++;
         $display("FAIL ovf_set kovf,rdy at c+1 got %b%b want 10", o_kovf[1], o_ready[1]);
      end
      checks++;
      if (o_done[len-1] !== 1'b1 || o_kovf[len] !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky done at c+%0d=%b kovf after done=%b want 1 1", len - 1, o_done[len-1], o_kovf[len]);
      end
      for (int i = 0; i < M; i++) begin
         checks++;
         if (ox[GAP+K_MAX+i][i] !== ta[i][K_MAX-1]) begin
            errors++;
            $display("FAIL ovf_last_slice lane %0d got %0d want %0d", i, ox[GAP+K_MAX+i][i], ta[i][K_MAX-1]);
         end
      end
      rand_tile();
      run_tile(2, 1'b1, 1'b0);
      checks++;
      if (o_kovf[1] !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear next tile kovf got %b want 0", o_kovf[1]);
      end
   endtask

   task automatic test_rst_mid_stream();
      logic [3:0] ctl;
      rand_tile();
      load_beats(2, 1'b1, 1'b0);
      for (int n = 1; n <= GAP + 3; n++) begin
         @(negedge clk);
         rand_inputs();
         in_valid = 1'b1;
      end
      checks++;
      if (array_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre array_en at t=2 got %b want 1", array_en);
      end
      rst = 1'b1;
      @(negedge clk);
      ctl = {busy, array_en, acc_clr, done};
      checks++;
      if (ctl !== 4'b0) begin
         errors++;
         $display("FAIL rst_mid_ctl (busy,en,clr,done) got %b want 0000", ctl);
      end
      for (int i = 0; i < M; i++) begin
         checks++;
         if (x_feed[i] !== '0 || y_feed[i] !== '0) begin
            errors++;
            $display("FAIL rst_mid_feeds lane %0d got x=%0d y=%0d want 0", i, x_feed[i], y_feed[i]);
         end
      end
      rst = 1'b0;
      idle_inputs();
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         checks++;
         if ({in_ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_idle cycle %0d (rdy,busy,done) got %b want 100", n, {in_ready, busy, done});
         end
      end
      test_random_tiles(1, 1'b0, "post_rst");
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_single_beat();
      test_overflow();
      test_random_tiles(6, 1'b0, "rand");
      test_random_tiles(3, 1'b1, "hold_valid");
      test_rst_mid_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder that drives the `x_in`/`y_in` edges of the MxM systolic array. It buffers an A tile (M rows × K columns) and a B tile (K rows × M columns) from a ready/valid stream, one k-slice per beat. It then replays them with the per-lane diagonal skew the array needs, so PE(i,j) accumulates sum over k of A[i][k]·B[k][j]. It also drives the array's `en` and an accumulator-clear pulse, and flags completion.

## Interface
- `N`, 32: operand width (signed, Q-format opaque to this block)
- `M`, 6: array dimension; lanes per edge
- `K_MAX`, 16: max inner dimension (buffer depth, beats)

Ports:
- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  load beat valid
- `in_ready`  out  1  feeder accepts beat
- `in_last`  in  1  beat is final k-slice
- `a_vec`  in  N×[0:M-1]  A[i][k], i=0..M-1 (signed)
- `b_vec`  in  N×[0:M-1]  B[k][j], j=0..M-1 (signed)
- `x_feed`  out  N×[0:M-1]  to array `x_in`
- `y_feed`  out  N×[0:M-1]  to array `y_in`
- `array_en`  out  1  to array `en`
- `acc_clr`  out  1  one-cycle accumulator clear (integrator ORs into array `rst`)
- `busy`  out  1  not in IDLE
- `done`  out  1  one-cycle pulse, tile fully streamed
- `k_ovf`  out  1  sticky: K_MAX reached without `in_last`

## Operation
- States: IDLE → LOAD → CLR → STREAM → DONE → IDLE.
- IDLE/LOAD: `in_ready`=1. A beat transfers when `in_valid && in_ready`. It is written at index `kcnt`, then `kcnt++`. First beat moves IDLE→LOAD.
- Beat with `in_last`=1, or the K_MAX-th beat, ends loading. K = beats taken (1..K_MAX). Forced end without `in_last` sets `k_ovf` (cleared only by `rst` or next accepted first beat).
- CLR: one cycle, `acc_clr`=1, `array_en`=0.
- STREAM: T = K+2M-1 cycles, counter t=0..T-1, `array_en`=1.
  - `x_feed[i]` = A[i][t-i] if 0 ≤ t-i < K, else 0.
  - `y_feed[j]` = B[t-j][j] if 0 ≤ t-j < K, else 0.
  - The final cycle (t=T-1) is all-zero flush, giving the PE pipeline its last step.
- DONE: one cycle, `done`=1, `array_en`=0, feeds 0. Then IDLE, buffer logically empty (kcnt=0).
- Outside STREAM, `x_feed`/`y_feed` are 0.
- No arithmetic. Values pass bit-exact. Counters sized $clog2(K_MAX+2M).

## Timing
- Reset (while `rst`=1 and the first cycle after): `in_ready`=0 during rst, then 1 in IDLE. `x_feed`/`y_feed`=0, `array_en`=0, `acc_clr`=0, `busy`=0, `done`=0, `k_ovf`=0.
- Last beat accepted at cycle c:
  - `in_ready`=0 from c+1.
  - `acc_clr` at c+1.
  - `array_en` for c+2..c+1+T.
  - `done` at c+2+T.
  - `in_ready`=1 again at c+3+T.
- Outputs are registered. `in_ready` is decoded from state only, with no combinational path from `in_valid`.
- `in_valid` while `in_ready`=0: ignored, no state change.
- `rst` mid-LOAD/STREAM: next cycle IDLE, all outputs at reset values, no `done`, loaded data discarded.
- Single-beat tile (K=1): T=2M. Valid.

## Configuration
- `SYSTOLIC_FEEDER_CLR_EN`: defined → CLR state present, `acc_clr` pulses as above.
- Undefined → CLR state removed, `acc_clr` tied 0. STREAM begins at c+1, `done` at c+1+T, `in_ready` high at c+2+T. Accumulators must then be cleared externally.

## Test plan
- M=2, N=16. Beats a={1,3},b={5,6} then a={2,4},b={7,8} with `in_last`:
  - x0=1,2,0,0,0; x1=0,3,4,0,0; y0=5,7,0,0,0; y1=0,6,8,0,0 over 5 `array_en` cycles.
  - Array acc_sum = 19,22,43,50.
  - `done` exactly at c+2+T.
- K=1, M=2, a={-3,7}, b={2,-1}: feeds x0=-3,0,0,0; x1=0,7,0,0; y0=2,0,0,0; y1=0,-1,0,0. Negative values pass bit-exact.
- K_MAX=4, four beats with no `in_last`: 4th beat ends load. `k_ovf`=1 and stays after `done`. Next tile's first beat clears it.
- `in_valid` held high through CLR/STREAM with changing data: no extra beats captured, stream data unchanged.
- `rst` asserted at STREAM t=2: next cycle `array_en`=0, feeds 0, `busy`=0, no `done`. Subsequent tile streams correctly.
- Build without `SYSTOLIC_FEEDER_CLR_EN`: `acc_clr` never 1 and `array_en` starts at c+1. The build with the macro shows the one-cycle `acc_clr` gap.
